// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared register offsets, FSM encodings and helpers for the interrupt controller
package irq_controller_pkg;

  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_EDGE = 2'd2;
  localparam logic [1:0] IRQ_VECT = 2'd3;

  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_HOLD   = 2'd2
  } irq_state_e;

  function automatic logic [31:0] vect_word(input logic valid, input logic [2:0] idx);
    return {valid, 28'd0, idx};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder over N request bits
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller driving the CPU HW_INT lines
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          N_IRQ     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int          HOLD_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      DEV_ADDR,
  input  logic [31:0]      DEV_WDATA,
  input  logic             DEV_WE,
  output logic [31:0]      DEV_RDATA,
  input  logic [N_IRQ-1:0] IRQ_IN,
  output logic [5:0]       HW_INT
);

  logic [N_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, edge_q, edge_d;
  logic [N_IRQ-1:0] irq_prev_q, masked, clr, edge_set;
  logic [5:0]       hw_q, hw_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  irq_state_e       state_q, state_d;
  logic             hit, wr, ack, valid;
  logic [1:0]       reg_sel;
  logic [2:0]       idx;
  logic             unused_bits;

  assign unused_bits = ^{DEV_ADDR[1:0], DEV_WDATA[31:N_IRQ]};

  assign hit     = (DEV_ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = DEV_ADDR[3:2];
  assign wr      = DEV_WE && hit;
  assign masked  = pend_q & mask_q;

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .req   (masked),
    .valid (valid),
    .idx   (idx)
  );

  // Acknowledge only counts while a request is actually being presented.
  assign ack      = wr && (reg_sel == IRQ_VECT) && (state_q == IRQ_ASSERT) && valid;
  assign edge_set = IRQ_IN & ~irq_prev_q;

  always_comb begin
    clr = '0;
    if (wr && reg_sel == IRQ_PEND) clr = DEV_WDATA[N_IRQ-1:0];
    if (ack) clr = clr | (N_IRQ'(1) << idx);
    pend_d = (edge_q & ((pend_q & ~clr) | edge_set)) | (~edge_q & IRQ_IN);
    mask_d = (wr && reg_sel == IRQ_MASK) ? DEV_WDATA[N_IRQ-1:0] : mask_q;
    edge_d = (wr && reg_sel == IRQ_EDGE) ? DEV_WDATA[N_IRQ-1:0] : edge_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hw_d    = '0;
    case (state_q)
      IRQ_IDLE: begin
        if (valid) begin
          state_d = IRQ_ASSERT;
          hw_d    = 6'(masked);
        end
      end
      IRQ_ASSERT: begin
        if (ack) begin
          state_d = IRQ_HOLD;
          cnt_d   = HOLD_W'(HOLD_CYC);
        end else if (!valid) begin
          state_d = IRQ_IDLE;
        end else begin
          hw_d = 6'(masked);
        end
      end
      IRQ_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        // Leaving the window re-presents pending work straight away, so the
        // line stays low for exactly HOLD_CYC cycles.
        if (cnt_q <= 1) begin
          cnt_d = '0;
          if (valid) begin
            state_d = IRQ_ASSERT;
            hw_d    = 6'(masked);
          end else begin
            state_d = IRQ_IDLE;
          end
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      mask_q     <= '0;
      edge_q     <= '1;
      irq_prev_q <= '0;
      hw_q       <= '0;
      cnt_q      <= '0;
      state_q    <= IRQ_IDLE;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_prev_q <= IRQ_IN;
      hw_q       <= hw_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    DEV_RDATA = '0;
    if (hit) begin
      case (reg_sel)
        IRQ_PEND: DEV_RDATA = 32'(pend_q);
        IRQ_MASK: DEV_RDATA = 32'(mask_q);
        IRQ_EDGE: DEV_RDATA = 32'(edge_q);
        default:  DEV_RDATA = vect_word(valid, idx);
      endcase
    end
  end

  assign HW_INT = hw_q;

endmodule
